// File: rtl/shifter_operand_decoder.sv
// Decodes the ARM data-processing shifter operand into a registered bundle: value, amount, shift op, illegal flag.
// Optional SHIFTOP_REG_SHIFT_EN enables register-specified shifts; when undefined they decode as illegal.
module shifter_operand_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        rf_rd_en,
    output logic [3:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_shift_value,
    output logic [2:0]  out_op_select,
    output logic        out_illegal
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_RM = 3'd1,
        RD_RS = 3'd2,
        CAP   = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_RRX = 3'd4;

    state_t      state_q, state_d;
    // Retained instr[11:4]: [7:4]=Rs, [7:3]=shift_imm, [2:1]=shift type, [0]=register-shift flag
    logic [7:0]  fields_q, fields_d;
    logic        valid_d, illegal_d, rd_en_d;
    logic [3:0]  rd_addr_d;
    logic [31:0] data_d;
    logic [7:0]  shift_d;
    logic [2:0]  op_d;
    logic        reg_shift_in;

    wire unused_instr_bits = &{1'b0, in_instr[31:26], in_instr[24:12]};

    wire [4:0] shift_imm = fields_q[7:3];
    wire [1:0] shift_typ = fields_q[2:1];

`ifdef SHIFTOP_REG_SHIFT_EN
    assign reg_shift_in = 1'b1;
`else
    assign reg_shift_in = 1'b0;
`endif

    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        fields_d  = fields_q;
        valid_d   = out_valid;
        illegal_d = out_illegal;
        rd_en_d   = 1'b0;
        rd_addr_d = 4'd0;
        data_d    = out_data;
        shift_d   = out_shift_value;
        op_d      = out_op_select;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    fields_d = in_instr[11:4];
                    if (in_instr[25]) begin
                        state_d   = OUT;
                        valid_d   = 1'b1;
                        illegal_d = 1'b0;
                        data_d    = {24'b0, in_instr[7:0]};
                        shift_d   = {3'b0, in_instr[11:8], 1'b0};
                        op_d      = OP_ROR;
                    end else if (in_instr[4] && (in_instr[7] || !reg_shift_in)) begin
                        state_d   = OUT;
                        valid_d   = 1'b1;
                        illegal_d = 1'b1;
                        data_d    = 32'd0;
                        shift_d   = 8'd0;
                        op_d      = OP_LSL;
                    end else begin
                        state_d   = RD_RM;
                        valid_d   = 1'b0;
                        illegal_d = 1'b0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = in_instr[3:0];
                    end
                end
            end
            RD_RM: begin
`ifdef SHIFTOP_REG_SHIFT_EN
                if (fields_q[0]) begin
                    state_d   = RD_RS;
                    rd_en_d   = 1'b1;
                    rd_addr_d = fields_q[7:4];
                end else begin
                    state_d = CAP;
                end
`else
                state_d = CAP;
`endif
            end
`ifdef SHIFTOP_REG_SHIFT_EN
            RD_RS: begin
                // Rm arrives here, one cycle after its read was issued
                data_d  = rf_rd_data;
                state_d = CAP;
            end
`endif
            CAP: begin
                state_d = OUT;
                valid_d = 1'b1;
                op_d    = {1'b0, shift_typ};
                if (fields_q[0]) begin
                    shift_d = rf_rd_data[7:0];
                end else begin
                    data_d = rf_rd_data;
                    if (shift_imm == 5'd0 && shift_typ != 2'b00) begin
                        if (shift_typ == 2'b11) begin
                            op_d    = OP_RRX;
                            shift_d = 8'd1;
                        end else begin
                            shift_d = 8'd32;
                        end
                    end else begin
                        shift_d = {3'b0, shift_imm};
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            fields_q        <= 8'd0;
            out_valid       <= 1'b0;
            out_illegal     <= 1'b0;
            rf_rd_en        <= 1'b0;
            rf_rd_addr      <= 4'd0;
            out_data        <= 32'd0;
            out_shift_value <= 8'd0;
            out_op_select   <= 3'd0;
        end else begin
            state_q         <= state_d;
            fields_q        <= fields_d;
            out_valid       <= valid_d;
            out_illegal     <= illegal_d;
            rf_rd_en        <= rd_en_d;
            rf_rd_addr      <= rd_addr_d;
            out_data        <= data_d;
            out_shift_value <= shift_d;
            out_op_select   <= op_d;
        end
    end

endmodule
